// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM state codes,
// requester port ids and the width of the D-grant streak counter.
package mem_arb_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_I = 3'd1;
  localparam logic [2:0] ST_BUSY_D = 3'd2;
  localparam logic [2:0] ST_DONE_I = 3'd3;
  localparam logic [2:0] ST_DONE_D = 3'd4;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with asynchronous reset and a synchronous clear
// that takes precedence over increment.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between instruction fetch (I) and
// data (D) ports; D has priority, bounded by a streak limit while I waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic [CNT_W-1:0]  conflict_count,
  output logic              spurious_ack
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  logic [2:0]          state_q, state_d;
  logic                grant;
  logic                grant_port;
  logic                streak_inc, streak_clr;
  logic [STREAK_W-1:0] streak_q;
  logic                conflict_inc;

  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic                m_we_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                spurious_q;

  // Grant decision and streak bookkeeping happen only in IDLE; BUSY waits
  // for the memory and DONE spends one cycle presenting the ready pulse.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_port = PORT_I;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_req && !(i_req && (streak_q == STREAK_LIM))) begin
          grant      = 1'b1;
          grant_port = PORT_D;
          state_d    = ST_BUSY_D;
          streak_inc = i_req;
          streak_clr = !i_req;
        end else if (i_req) begin
          grant      = 1'b1;
          grant_port = PORT_I;
          state_d    = ST_BUSY_I;
          streak_clr = 1'b1;
        end
      end
      ST_BUSY_I: if (m_ack) state_d = ST_DONE_I;
      ST_BUSY_D: if (m_ack) state_d = ST_DONE_D;
      ST_DONE_I: state_d = ST_IDLE;
      ST_DONE_D: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign conflict_inc = (state_q == ST_IDLE) && i_req && d_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_we_q     <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (grant) begin
        if (grant_port == PORT_D) begin
          m_addr_q  <= d_addr;
          m_wdata_q <= d_wdata;
          m_we_q    <= d_we;
        end else begin
          m_addr_q <= i_addr;
          m_we_q   <= 1'b0;
        end
      end
      // An ack outside BUSY carries no data and only flags the protocol error.
      if (m_ack) begin
        if (state_q == ST_BUSY_I) begin
          i_rdata_q <= m_rdata;
        end else if (state_q == ST_BUSY_D) begin
          if (!m_we_q) d_rdata_q <= m_rdata;
        end else begin
          spurious_q <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(STREAK_W)) u_streak (
    .clock (clock),
    .reset (reset),
    .clr   (streak_clr),
    .inc   (streak_inc),
    .q     (streak_q)
  );

  sat_counter #(.W(CNT_W)) u_conflict (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (conflict_inc),
    .q     (conflict_count)
  );

  assign m_req        = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign i_ready      = (state_q == ST_DONE_I);
  assign d_ready      = (state_q == ST_DONE_D);
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign m_we         = m_we_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign spurious_ack = spurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions,
// a monitor pops and checks them on every ready pulse.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, spurious_ack;
  logic [15:0] conflict_count;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STREAK_MAX(4), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .conflict_count(conflict_count), .spurious_ack(spurious_ack)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    logic [31:0] data;
    string       tag;
  } exp_t;
  exp_t sb[$];

  // Memory model: acks on the lat-th cycle of m_req, data = addr ^ 0x8C01_0044.
  int unsigned lat = 3;
  bit          force_ack = 1'b0;
  int unsigned busy_cnt = 0;
  initial begin
    m_ack   = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      m_ack = 1'b0;
      if (force_ack) begin
        m_ack   = 1'b1;
        m_rdata = 32'hA5A5_5A5A;
      end else if (m_req) begin
        busy_cnt++;
        if (busy_cnt >= lat) begin
          m_ack    = 1'b1;
          m_rdata  = m_addr ^ 32'h8C01_0044;
          busy_cnt = 0;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (i_ready || d_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got i_ready=%0d d_ready=%0d want none", i_ready, d_ready);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_port"}, {31'b0, d_ready}, {31'b0, e.port});
          check({e.tag, "_rdata"}, d_ready ? d_rdata : i_rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input bit is_d, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clock);
      if (is_d ? d_ready : i_ready) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: got=no ready want=ready", name);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_req"},   {31'b0, m_req},   32'h0);
    check({tag, "_m_we"},    {31'b0, m_we},    32'h0);
    check({tag, "_i_ready"}, {31'b0, i_ready}, 32'h0);
    check({tag, "_d_ready"}, {31'b0, d_ready}, 32'h0);
    check({tag, "_m_addr"},  m_addr,  32'h0);
    check({tag, "_m_wdata"}, m_wdata, 32'h0);
    check({tag, "_i_rdata"}, i_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
    check({tag, "_conflict"}, {16'b0, conflict_count}, 32'h0);
    check({tag, "_spurious"}, {31'b0, spurious_ack}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned d_idx;
    bit seen_d, seen_i;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Test 1: fetch, k=3 -> m_req cycles 1..3, i_ready cycle 4.
    lat = 3;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    sb.push_back('{1'b0, 32'h8C01_0004, "t1_fetch"});
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      check($sformatf("t1_m_req_c%0d", c), {31'b0, m_req}, (c >= 1 && c <= 3) ? 32'h1 : 32'h0);
      check($sformatf("t1_i_ready_c%0d", c), {31'b0, i_ready}, (c == 4) ? 32'h1 : 32'h0);
      if (c >= 1 && c <= 3) begin
        check("t1_m_addr", m_addr, 32'h0000_0040);
        check("t1_m_we", {31'b0, m_we}, 32'h0);
      end
    end
    tick();
    i_req = 1'b0;

    // Test 2: store; d_rdata must keep its reset value.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 32'h0000_0000, "t2_store"});
    @(negedge clock);
    @(negedge clock);
    check("t2_m_req", {31'b0, m_req}, 32'h1);
    check("t2_m_we", {31'b0, m_we}, 32'h1);
    check("t2_m_addr", m_addr, 32'h0000_0100);
    check("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
    wait_ready(1'b1, "t2");
    tick();
    d_req = 1'b0; d_we = 1'b0;

    // Test 3: simultaneous requests, D wins, then I.
    lat = 2;
    check("t3_conflict_before", {16'b0, conflict_count}, 32'h0);
    i_req = 1'b1; i_addr = 32'h0000_0044;
    d_req = 1'b1; d_addr = 32'h0000_0200;
    sb.push_back('{1'b1, 32'h8C01_0244, "t3_d"});
    sb.push_back('{1'b0, 32'h8C01_0000, "t3_i"});
    wait_ready(1'b1, "t3_d");
    tick();
    d_req = 1'b0;
    wait_ready(1'b0, "t3_i");
    tick();
    i_req = 1'b0;
    check("t3_conflict", {16'b0, conflict_count}, 32'h1);

    // Test 4: D held back-to-back with I pending: D,D,D,D,I,D.
    i_req = 1'b1; i_addr = 32'h0000_0080;
    d_req = 1'b1; d_addr = 32'h0000_0300;
    sb.push_back('{1'b1, 32'h8C01_0344, "t4_d0"});
    sb.push_back('{1'b1, 32'h8C01_0340, "t4_d1"});
    sb.push_back('{1'b1, 32'h8C01_034C, "t4_d2"});
    sb.push_back('{1'b1, 32'h8C01_0348, "t4_d3"});
    sb.push_back('{1'b0, 32'h8C01_00C4, "t4_i"});
    sb.push_back('{1'b1, 32'h8C01_0354, "t4_d4"});
    d_idx = 0;
    for (int n = 0; n < 200 && (d_req || i_req); n++) begin
      @(negedge clock);
      seen_d = d_ready;
      seen_i = i_ready;
      if (seen_d || seen_i) begin
        tick();
        if (seen_d) begin
          d_idx++;
          if (d_idx < 5) d_addr = 32'h0000_0300 + 32'(4 * d_idx);
          else d_req = 1'b0;
        end
        if (seen_i) i_req = 1'b0;
      end
    end
    check("t4_done", {30'b0, d_req, i_req}, 32'h0);
    check("t4_conflict", {16'b0, conflict_count}, 32'h6);

    // Test 6: ack while IDLE is sticky and touches no data.
    tick();
    check("t6_spurious_before", {31'b0, spurious_ack}, 32'h0);
    force_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    force_ack = 1'b0;
    tick();
    @(negedge clock);
    check("t6_spurious", {31'b0, spurious_ack}, 32'h1);
    check("t6_i_rdata", i_rdata, 32'h8C01_00C4);
    check("t6_d_rdata", d_rdata, 32'h8C01_0354);
    repeat (3) @(negedge clock);
    check("t6_spurious_sticky", {31'b0, spurious_ack}, 32'h1);

    // Test 5: reset in the 2nd cycle of BUSY_D abandons the access.
    lat = 6;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    tick();
    tick();
    check("t5_busy", {31'b0, m_req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("t5_reset");
    d_req = 1'b0;
    tick();
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("t5_m_req_after", {31'b0, m_req}, 32'h0);

    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
